riscy: RTL and testbench
========================

// Module: riscy
// PURPOSE
// - Small multi-cycle 8-bit load/store processor: 32x32 instruction ROM, 32xOUT_WIDTH data RAM, 8 GPRs.
// - One bidirectional I/O port.
// - Top of the CPU; the bench preloads the ROM via $readmemh, runs the program, then dumps RAM hierarchically.
// PARAMETERS
// - OUT_WIDTH  8  data width: GPRs, ALU, RAM words, IO port
// PORTS
// - CLK  in     1          single clock, rising edge
// - RST  in     1          asynchronous, active-high reset
// - IO   inout  OUT_WIDTH  bidirectional I/O port
// BEHAVIOUR
// - Instruction fields:
//   - [31:28] OP, [27:25] RD, [24:22] RS, [21:17] ADDR (5b RAM/jump address), [OUT_WIDTH-1:0] IMM.
//   - Other bits are ignored.
// - Opcodes (decode unlisted values as NOP; the set is complete, so none remain):
//   - 0 NOP
//   - 1 LDI RD<=IMM
//   - 2 LD RD<=RAM[ADDR]
//   - 3 ST RAM[ADDR]<=RD
//   - 4 ADD RD<=RD+RS
//   - 5 SUB RD<=RD-RS
//   - 6 AND
//   - 7 OR
//   - 8 XOR
//   - 9 NOT RD<=~RD
//   - A IN RD<=IO
//   - B OUT outreg<=RD
//   - C JMP PC<=ADDR
//   - D JZ (if Z)
//   - E JC (if C)
//   - F HALT
// - FSM FETCH->DECODE->EXEC->FETCH: 3 cycles per instruction, no pipelining.
//   - FETCH: IR<=ROM[PC].
//   - DECODE: read operands.
//   - EXEC: write result, RAM, flags and PC.
// - PC is 5 bits.
//   - EXEC: PC<=ADDR on a taken jump, else PC+1.
//   - Wraps 31->0.
// - HALT: FSM parks in HALTED; PC, regs and RAM frozen until RST.
// - Flags:
//   - Z and C are updated only by ADD/SUB/AND/OR/XOR/NOT.
//   - Z = (result==0).
//   - C = carry-out of ADD, borrow of SUB; logic ops clear C.
//   - Arithmetic is modulo 2^OUT_WIDTH.
// - IO:
//   - Internal net PORT_RD is high only during EXEC of IN; IO is sampled on that edge.
//   - DUT drives IO = outreg when out_en=1 and PORT_RD=0, else 'z.
//   - out_en is set by the first OUT and stays set.
// - RAM: synchronous write in EXEC of ST; asynchronous read.
//   - ST then LD to the same ADDR returns the new value.
// - ROM: read-only array, no reset/init in RTL; contents come from $readmemh.
// - Reset (async, any state, mid-instruction included) clears:
//   - PC, IR, all GPRs, Z, C, outreg, out_en; PORT_RD=0, IO='z, FSM=FETCH.
//   - All 32 RAM words <= 0.
//   - Instruction in flight is abandoned, with no partial writes.
// - Hierarchy is fixed for bench access:
//   - Net PORT_RD at top.
//   - Instance MEM_SUBSYSTEM containing instances ROM_32x32 and RAM_32x8.
//   - Each has storage array MEM_ARRAY: ROM [31:0] x32, RAM [OUT_WIDTH-1:0] x32.
// STRUCTURE
// - Package riscy_pkg:
//   - opcode enum (4b), state enum {FETCH,DECODE,EXEC,HALTED}.
//   - Field bit positions, ROM_DEPTH=32, RAM_DEPTH=32.
// - Sub-module riscy_mem (instance MEM_SUBSYSTEM):
//   - ROM_32x32 and RAM_32x8 with read/write ports.
// - Top holds FSM, PC/IR, 8xOUT_WIDTH register file, ALU, IO tri-state.
// TESTING
// - Reset: RST=1 for 2 cycles -> PC=0, IO='z, PORT_RD=0, RAM all 00.
//   - Assert RST mid-EXEC of an ST -> no RAM write.
// - Program LDI r1,0x05; LDI r2,0x03; ADD r1,r2; ST r1,@0x00.
//   - Expect RAM[00]=08 after 12 cycles, Z=0, C=0.
// - LDI r1,0xFF; LDI r2,0x01; ADD r1,r2; ST r1,@0x1F; JZ 0x10.
//   - Expect RAM[1F]=00, Z=1, C=1, next fetch from PC=0x10.
// - Bench drives DIN=0xAA when PORT_RD=1; IN r3; ST r3,@0x02; NOT r3; OUT r3.
//   - Expect RAM[02]=AA, IO=55 driven after OUT, no contention during IN.
// - PC wrap: 32 NOPs then ST at ROM[0] re-executed.
//   - PC goes 31->0 after 96 cycles.
// - HALT: HALT at ROM[4].
//   - PC stays 5 and RAM is unchanged for 100 cycles.

Source files
------------

// File: rtl/riscy_pkg.sv
// riscy_pkg: shared opcodes, FSM states, instruction field positions and memory depths
package riscy_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOT, OP_IN, OP_OUT, OP_JMP, OP_JZ, OP_JC, OP_HALT
    } opcode_t;
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALTED} state_t;
    localparam int OP_HI = 31;
    localparam int OP_LO = 28;
    localparam int RD_HI = 27;
    localparam int RD_LO = 25;
    localparam int RS_HI = 24;
    localparam int RS_LO = 22;
    localparam int ADDR_HI = 21;
    localparam int ADDR_LO = 17;
    localparam int ROM_DEPTH = 32;
    localparam int RAM_DEPTH = 32;
endpackage

// File: rtl/riscy_mem.sv
// riscy_mem: instruction ROM and data RAM of the riscy CPU
//   riscy_rom : addr -> data, combinational read of MEM_ARRAY (preloaded externally)
//   riscy_ram : clk, rst (async clear of all words), we/addr/wdata sync write, rdata async read
//   riscy_mem : wraps both as ROM_32x32 and RAM_32x8
module riscy_rom
    import riscy_pkg::*;
(
    input  logic [4:0]  addr,
    output logic [31:0] data
);
    logic [31:0] MEM_ARRAY [ROM_DEPTH];
    assign data = MEM_ARRAY[addr];
endmodule

module riscy_ram
    import riscy_pkg::*;
#(
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [4:0]           addr,
    input  logic [OUT_WIDTH-1:0] wdata,
    output logic [OUT_WIDTH-1:0] rdata
);
    logic [OUT_WIDTH-1:0] MEM_ARRAY [RAM_DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < RAM_DEPTH; i++) MEM_ARRAY[i] <= '0;
        else if (we)
            MEM_ARRAY[addr] <= wdata;
    end
    assign rdata = MEM_ARRAY[addr];
endmodule

module riscy_mem #(
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rom_addr,
    output logic [31:0]          rom_data,
    input  logic                 ram_we,
    input  logic [4:0]           ram_addr,
    input  logic [OUT_WIDTH-1:0] ram_wdata,
    output logic [OUT_WIDTH-1:0] ram_rdata
);
    riscy_rom ROM_32x32 (
        .addr(rom_addr),
        .data(rom_data)
    );
    riscy_ram #(.OUT_WIDTH(OUT_WIDTH)) RAM_32x8 (
        .clk(clk),
        .rst(rst),
        .we(ram_we),
        .addr(ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );
endmodule

// File: rtl/riscy.sv
// riscy: multi-cycle 8-bit load/store CPU (FETCH -> DECODE -> EXEC, HALT parks in HALTED)
//   CLK : rising-edge clock
//   RST : asynchronous active-high reset
//   IO  : bidirectional port, driven with outreg once OUT has run, released while IN samples it
module riscy
    import riscy_pkg::*;
#(
    parameter int OUT_WIDTH = 8
) (
    input logic                 CLK,
    input logic                 RST,
    inout wire  [OUT_WIDTH-1:0] IO
);
    state_t state, state_n;
    opcode_t op;
    logic [4:0] pc, addr;
    logic [31:0] ir, rom_data;
    logic [2:0] rd, rs;
    logic [OUT_WIDTH-1:0] regs [8];
    logic [OUT_WIDTH-1:0] a, b, imm, res, outreg, ram_rdata;
    logic [OUT_WIDTH:0] sum, diff;
    logic z, c, cout, wr, alu, taken, out_en, ram_we, io_oe, PORT_RD;
    logic unused_bits;
    assign op = opcode_t'(ir[OP_HI:OP_LO]);
    assign rd = ir[RD_HI:RD_LO];
    assign rs = ir[RS_HI:RS_LO];
    assign addr = ir[ADDR_HI:ADDR_LO];
    assign imm = ir[OUT_WIDTH-1:0];
    assign unused_bits = ^ir[ADDR_LO-1:OUT_WIDTH];
    assign ram_we = state == EXEC && op == OP_ST;
    assign PORT_RD = state == EXEC && op == OP_IN;
    // The port is released during IN so the external driver never fights outreg.
    assign io_oe = out_en && !PORT_RD;
    assign IO = io_oe ? outreg : 'z;
    riscy_mem #(.OUT_WIDTH(OUT_WIDTH)) MEM_SUBSYSTEM (
        .clk(CLK),
        .rst(RST),
        .rom_addr(pc),
        .rom_data(rom_data),
        .ram_we(ram_we),
        .ram_addr(addr),
        .ram_wdata(a),
        .ram_rdata(ram_rdata)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= FETCH;
        else state <= state_n;
    end
    always_comb begin
        state_n = state == FETCH  ? DECODE :
                  state == DECODE ? EXEC :
                  state == EXEC   ? (op == OP_HALT ? HALTED : FETCH) : HALTED;
    end
    // Extra top bit of sum/diff is the carry-out of ADD and the borrow of SUB.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        res = '0;
        cout = 1'b0;
        wr = 1'b0;
        alu = 1'b0;
        taken = 1'b0;
        case (op)
            OP_LDI: begin res = imm; wr = 1'b1; end
            OP_LD:  begin res = ram_rdata; wr = 1'b1; end
            OP_ADD: begin {cout, res} = sum; wr = 1'b1; alu = 1'b1; end
            OP_SUB: begin {cout, res} = diff; wr = 1'b1; alu = 1'b1; end
            OP_AND: begin res = a & b; wr = 1'b1; alu = 1'b1; end
            OP_OR:  begin res = a | b; wr = 1'b1; alu = 1'b1; end
            OP_XOR: begin res = a ^ b; wr = 1'b1; alu = 1'b1; end
            OP_NOT: begin res = ~a; wr = 1'b1; alu = 1'b1; end
            OP_IN:  begin res = IO; wr = 1'b1; end
            OP_JMP: taken = 1'b1;
            OP_JZ:  taken = z;
            OP_JC:  taken = c;
            default: ;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= '0;
            ir <= '0;
            a <= '0;
            b <= '0;
            z <= 1'b0;
            c <= 1'b0;
            outreg <= '0;
            out_en <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (state == FETCH) begin
            ir <= rom_data;
        end else if (state == DECODE) begin
            a <= regs[rd];
            b <= regs[rs];
        end else if (state == EXEC) begin
            if (wr) regs[rd] <= res;
            if (alu) begin
                z <= res == '0;
                c <= cout;
            end
            if (op == OP_OUT) begin
                outreg <= a;
                out_en <= 1'b1;
            end
            pc <= taken ? addr : pc + 5'd1;
        end
    end
endmodule

// File: tb/tb_riscy.sv
// tb_riscy: directed-program bench for riscy, ROM preloaded and RAM inspected hierarchically
module tb_riscy;
    import riscy_pkg::*;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [7:0] din = 8'hAA;
    wire [7:0] io;
    int checks = 0;
    int failures = 0;
    int nz;
    assign io = dut.PORT_RD ? din : 8'hzz;
    riscy #(.OUT_WIDTH(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .IO(io)
    );
    always #5 CLK = ~CLK;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] enc(opcode_t op, logic [2:0] rd, logic [2:0] rs, logic [4:0] ad, logic [7:0] imm);
        return {op, rd, rs, ad, 9'b0, imm};
    endfunction
    task automatic rom(input int a, input logic [31:0] w);
        dut.MEM_SUBSYSTEM.ROM_32x32.MEM_ARRAY[a] = w;
    endtask
    function automatic logic [7:0] ram(input int a);
        return dut.MEM_SUBSYSTEM.RAM_32x8.MEM_ARRAY[a];
    endfunction
    task automatic start;
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < ROM_DEPTH; i++) rom(i, 32'h0);
    endtask
    task automatic go;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask
    task automatic run(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask
    initial begin
        start();
        go();
        check("rst_pc", dut.pc, 0);
        check("rst_state", dut.state, FETCH);
        check("rst_port_rd", dut.PORT_RD, 0);
        check("rst_io_oe", dut.io_oe, 0);
        nz = 0;
        for (int i = 0; i < RAM_DEPTH; i++) if (ram(i) != 0) nz++;
        check("rst_ram_clear", nz, 0);

        start();
        rom(0, enc(OP_LDI, 1, 0, 0, 8'h05));
        rom(1, enc(OP_LDI, 2, 0, 0, 8'h03));
        rom(2, enc(OP_ADD, 1, 2, 0, 0));
        rom(3, enc(OP_ST, 1, 0, 0, 0));
        go();
        run(12);
        check("add_ram0", ram(0), 8'h08);
        check("add_z", dut.z, 0);
        check("add_c", dut.c, 0);
        check("add_pc", dut.pc, 4);

        start();
        rom(0, enc(OP_LDI, 1, 0, 0, 8'h77));
        rom(1, enc(OP_ST, 1, 0, 5'h05, 0));
        go();
        check("rst_clears_old_ram", ram(0), 0);
        run(5);
        check("mid_state_exec", dut.state, EXEC);
        RST = 1'b1;
        #1;
        check("async_state", dut.state, FETCH);
        check("async_pc", dut.pc, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("mid_st_no_write", ram(5), 0);
        check("mid_reg_clear", dut.regs[1], 0);

        start();
        rom(0, enc(OP_LDI, 1, 0, 0, 8'hFF));
        rom(1, enc(OP_LDI, 2, 0, 0, 8'h01));
        rom(2, enc(OP_ADD, 1, 2, 0, 0));
        rom(3, enc(OP_ST, 1, 0, 5'h1F, 0));
        rom(4, enc(OP_JZ, 0, 0, 5'h10, 0));
        rom(16, enc(OP_LDI, 4, 0, 0, 8'h5A));
        go();
        run(15);
        check("ovf_ram1f", ram(31), 8'h00);
        check("ovf_z", dut.z, 1);
        check("ovf_c", dut.c, 1);
        check("jz_pc", dut.pc, 5'h10);
        run(3);
        check("jz_target_exec", dut.regs[4], 8'h5A);

        start();
        rom(0, enc(OP_LDI, 1, 0, 0, 8'h03));
        rom(1, enc(OP_LDI, 2, 0, 0, 8'h05));
        rom(2, enc(OP_SUB, 1, 2, 0, 0));
        rom(3, enc(OP_JC, 0, 0, 5'd8, 0));
        rom(4, enc(OP_HALT, 0, 0, 0, 0));
        rom(8, enc(OP_ST, 1, 0, 5'd3, 0));
        rom(9, enc(OP_AND, 1, 2, 0, 0));
        rom(10, enc(OP_ST, 1, 0, 5'd4, 0));
        rom(11, enc(OP_XOR, 2, 2, 0, 0));
        rom(12, enc(OP_LD, 6, 0, 5'd3, 0));
        rom(13, enc(OP_JMP, 0, 0, 5'd15, 0));
        rom(14, enc(OP_HALT, 0, 0, 0, 0));
        rom(15, enc(OP_ST, 6, 0, 5'd5, 0));
        rom(16, enc(OP_HALT, 0, 0, 0, 0));
        go();
        run(9);
        check("sub_res", dut.regs[1], 8'hFE);
        check("sub_borrow", dut.c, 1);
        check("sub_z", dut.z, 0);
        run(27);
        check("jc_st_ram3", ram(3), 8'hFE);
        check("and_ram4", ram(4), 8'h04);
        check("ld_jmp_ram5", ram(5), 8'hFE);
        check("xor_z", dut.z, 1);
        check("logic_c", dut.c, 0);
        check("halt_pc17", dut.pc, 17);
        check("halted_state", dut.state, HALTED);

        start();
        rom(0, enc(OP_IN, 3, 0, 0, 0));
        rom(1, enc(OP_ST, 3, 0, 5'd2, 0));
        rom(2, enc(OP_NOT, 3, 0, 0, 0));
        rom(3, enc(OP_OUT, 3, 0, 0, 0));
        rom(4, enc(OP_IN, 5, 0, 0, 0));
        rom(5, enc(OP_ST, 5, 0, 5'd6, 0));
        rom(6, enc(OP_HALT, 0, 0, 0, 0));
        go();
        run(2);
        check("in_port_rd", dut.PORT_RD, 1);
        check("in_no_drive", dut.io_oe, 0);
        check("in_io_val", io, 8'hAA);
        run(10);
        check("in_ram2", ram(2), 8'hAA);
        check("out_io", io, 8'h55);
        check("out_oe", dut.io_oe, 1);
        check("not_z", dut.z, 0);
        run(2);
        check("in2_port_rd", dut.PORT_RD, 1);
        check("in2_no_contention", dut.io_oe, 0);
        check("in2_io_val", io, 8'hAA);
        run(7);
        check("in2_ram6", ram(6), 8'hAA);
        check("out_restored", io, 8'h55);

        start();
        rom(0, enc(OP_ST, 1, 0, 5'd9, 0));
        rom(1, enc(OP_LDI, 1, 0, 0, 8'h3C));
        go();
        check("rst_out_en", dut.out_en, 0);
        check("rst_io_released", dut.io_oe, 0);
        run(93);
        check("wrap_pc31", dut.pc, 31);
        run(3);
        check("wrap_pc0", dut.pc, 0);
        check("wrap_ram9_first", ram(9), 0);
        run(3);
        check("wrap_reexec", ram(9), 8'h3C);
        check("wrap_pc1", dut.pc, 1);

        start();
        rom(0, enc(OP_LDI, 1, 0, 0, 8'h11));
        rom(1, enc(OP_ST, 1, 0, 5'd8, 0));
        rom(2, enc(OP_LDI, 1, 0, 0, 8'h22));
        rom(4, enc(OP_HALT, 0, 0, 0, 0));
        rom(5, enc(OP_ST, 1, 0, 5'd8, 0));
        rom(6, enc(OP_JMP, 0, 0, 0, 0));
        go();
        run(15);
        check("halt_pc5", dut.pc, 5);
        check("halt_state", dut.state, HALTED);
        run(100);
        check("halt_pc_frozen", dut.pc, 5);
        check("halt_ram_frozen", ram(8), 8'h11);
        check("halt_reg_frozen", dut.regs[1], 8'h22);
        check("halt_parked", dut.state, HALTED);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
